// File: rtl/sim_harness_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sim_harness_pkg
// Description : Shared types and constants for the simulation stream harness.
//               Provides the harness state encoding and the default value of
//               the rx word that terminates a run.
// Revision    : 1.0 - initial release
// ============================================================================
package sim_harness_pkg;

  // Harness run states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default terminator word (ASCII EOT).
  localparam logic [7:0] DEFAULT_END_WORD = 8'h04;

endpackage
`default_nettype wire

// File: rtl/sim_word_ram.sv
`default_nettype none
// ============================================================================
// Module      : sim_word_ram
// Description : Simple one-write-port / one-read-port word memory. The read
//               port is either asynchronous (REG_READ=0) or registered with
//               one cycle of latency (REG_READ=1). Contents are not reset.
// Ports       : clock_i  - write/read clock, rising edge
//               we_i     - write strobe
//               waddr_i  - write address
//               wdata_i  - write data
//               raddr_i  - read address
//               rdata_o  - read data
// Revision    : 1.0 - initial release
// ============================================================================
module sim_word_ram #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter bit REG_READ = 1'b0
) (
  input  logic                     clock_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  generate
    if (REG_READ) begin : g_reg_read
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clock_i) begin
        rdata_q <= mem_q[raddr_i];
      end
      assign rdata_o = rdata_q;
    end else begin : g_async_read
      assign rdata_o = mem_q[raddr_i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sim_stream_harness.sv
`default_nettype none
// ============================================================================
// Module      : sim_stream_harness
// Description : Replays a loaded byte script into the SoC inbound tx stream
//               and captures the SoC outbound rx stream. A run ends when the
//               terminator word is accepted or after TIMEOUT run cycles, and
//               reports done / passed / timed_out / overflow.
// Ports       : clock_i, reset_i          - clock, synchronous active-high reset
//               script_we/addr/data_i     - script memory write port (not in RUN)
//               script_len_i, start_i     - run length (sampled at start), start
//               tx_valid/data_o, tx_ready_i - stream toward the SoC
//               rx_valid/data_i, rx_ready_o - stream from the SoC
//               cap_addr_i, cap_data_o    - capture read port (1-cycle latency)
//               done/passed/timed_out/overflow_o - status flags
//               rx_count_o, cycle_count_o - accepted words, run cycles
// Revision    : 1.0 - initial release
// ============================================================================
module sim_stream_harness
  import sim_harness_pkg::*;
#(
  parameter int                DATA_W          = 8,
  parameter int                SCRIPT_DEPTH    = 16,
  parameter int                CAPTURE_DEPTH   = 16,
  parameter int                TIMEOUT         = 1000,
  parameter logic [DATA_W-1:0] END_WORD        = DATA_W'(DEFAULT_END_WORD),
  parameter int                RX_STALL_PERIOD = 0
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            script_we_i,
  input  logic [$clog2(SCRIPT_DEPTH)-1:0] script_addr_i,
  input  logic [DATA_W-1:0]               script_data_i,
  input  logic [$clog2(SCRIPT_DEPTH):0]   script_len_i,
  input  logic                            start_i,
  output logic                            tx_valid_o,
  output logic [DATA_W-1:0]               tx_data_o,
  input  logic                            tx_ready_i,
  input  logic                            rx_valid_i,
  input  logic [DATA_W-1:0]               rx_data_i,
  output logic                            rx_ready_o,
  input  logic [$clog2(CAPTURE_DEPTH)-1:0] cap_addr_i,
  output logic [DATA_W-1:0]               cap_data_o,
  output logic                            done_o,
  output logic                            passed_o,
  output logic                            timed_out_o,
  output logic                            overflow_o,
  output logic [15:0]                     rx_count_o,
  output logic [31:0]                     cycle_count_o
);

  localparam int SAW        = $clog2(SCRIPT_DEPTH);
  localparam int CAW        = $clog2(CAPTURE_DEPTH);
  localparam bit STALL_EN   = (RX_STALL_PERIOD >= 2);
  localparam int STALL_LAST = STALL_EN ? RX_STALL_PERIOD - 1 : 0;

  state_t        state_q, state_d;
  logic [SAW:0]  tx_idx_q;
  logic [SAW:0]  len_q;
  logic [15:0]   rx_count_q;
  logic [31:0]   cycle_count_q;
  logic [15:0]   stall_q;
  logic          done_q, passed_q, timed_out_q, overflow_q;

  logic              w_run, w_start, w_tx_valid, w_tx_xfer, w_stall_slot;
  logic              w_rx_ready, w_accept, w_end, w_timeout, w_cap_we;
  logic [DATA_W-1:0] w_script_rd;

  assign w_run        = (state_q == RUN);
  assign w_start      = start_i && !w_run;
  assign w_tx_valid   = w_run && (tx_idx_q < len_q);
  assign w_tx_xfer    = w_tx_valid && tx_ready_i;
  assign w_stall_slot = STALL_EN && (stall_q == 16'(STALL_LAST));
  assign w_rx_ready   = w_run && !w_stall_slot;
  assign w_accept     = rx_valid_i && w_rx_ready;
  assign w_end        = w_accept && (rx_data_i == END_WORD);
  // The terminator wins over a coincident timeout.
  assign w_timeout    = w_run && (cycle_count_q == 32'(TIMEOUT - 1)) && !w_end;
  assign w_cap_we     = w_accept && ({1'b0, rx_count_q} < 17'(CAPTURE_DEPTH));

  // Script: asynchronous read so tx_data follows tx_idx with no bubble.
  sim_word_ram #(
    .WIDTH    (DATA_W),
    .DEPTH    (SCRIPT_DEPTH),
    .REG_READ (1'b0)
  ) u_script_ram (
    .clock_i (clock_i),
    .we_i    (script_we_i && !w_run),
    .waddr_i (script_addr_i),
    .wdata_i (script_data_i),
    .raddr_i (tx_idx_q[SAW-1:0]),
    .rdata_o (w_script_rd)
  );

  sim_word_ram #(
    .WIDTH    (DATA_W),
    .DEPTH    (CAPTURE_DEPTH),
    .REG_READ (1'b1)
  ) u_capture_ram (
    .clock_i (clock_i),
    .we_i    (w_cap_we),
    .waddr_i (rx_count_q[CAW-1:0]),
    .wdata_i (rx_data_i),
    .raddr_i (cap_addr_i),
    .rdata_o (cap_data_o)
  );

  // FSM state register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (w_end || w_timeout) state_d = DONE;
      DONE:    if (start_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. tx_data is forced to zero whenever no word is offered.
  always_comb begin
    tx_valid_o = w_tx_valid;
    tx_data_o  = w_tx_valid ? w_script_rd : '0;
    rx_ready_o = w_rx_ready;
  end

  // Run datapath: indices, counters and sticky status flags.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      tx_idx_q      <= '0;
      len_q         <= '0;
      rx_count_q    <= '0;
      cycle_count_q <= '0;
      stall_q       <= '0;
      done_q        <= 1'b0;
      passed_q      <= 1'b0;
      timed_out_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else if (w_start) begin
      tx_idx_q      <= '0;
      len_q         <= script_len_i;
      rx_count_q    <= '0;
      cycle_count_q <= '0;
      stall_q       <= '0;
      done_q        <= 1'b0;
      passed_q      <= 1'b0;
      timed_out_q   <= 1'b0;
      overflow_q    <= 1'b0;
    end else if (w_run) begin
      cycle_count_q <= cycle_count_q + 32'd1;
      if (w_tx_xfer) begin
        tx_idx_q <= tx_idx_q + 1'b1;
      end
      if (w_accept && (rx_count_q != 16'hFFFF)) begin
        rx_count_q <= rx_count_q + 16'd1;
      end
      if (w_accept && !w_cap_we) begin
        overflow_q <= 1'b1;
      end
      if (STALL_EN) begin
        stall_q <= w_stall_slot ? 16'd0 : stall_q + 16'd1;
      end
      if (w_end) begin
        done_q   <= 1'b1;
        passed_q <= (tx_idx_q == len_q);
      end else if (w_timeout) begin
        done_q      <= 1'b1;
        timed_out_q <= 1'b1;
        passed_q    <= 1'b0;
      end
    end
  end

  assign done_o        = done_q;
  assign passed_o      = passed_q;
  assign timed_out_o   = timed_out_q;
  assign overflow_o    = overflow_q;
  assign rx_count_o    = rx_count_q;
  assign cycle_count_o = cycle_count_q;

endmodule
`default_nettype wire

// File: doc/sim_stream_harness.md
# sim_stream_harness

Parametrised, self-checking stream harness for SoC simulation. It replays a loaded byte script into the SoC's inbound `tx_*` stream and captures the SoC's outbound `rx_*` stream into a buffer. It ends the run on a terminator byte or a cycle timeout, and reports pass/fail, which replaces a hard-wired "tx idle / rx always ready / fixed delay" bench. It sits in `sim/` between the clock/reset generator and `yarvi_soc`, and is synthesizable so FPGA bring-up can reuse it.

## Interface
- `DATA_W`, 8: stream word width.
- `SCRIPT_DEPTH`, 16: maximum script length in words (power of 2).
- `CAPTURE_DEPTH`, 16: capture buffer entries (power of 2).
- `TIMEOUT`, 1000: RUN cycles allowed before the run times out (≥1).
- `END_WORD`, 8'h04: rx word that terminates the run.
- `RX_STALL_PERIOD`, 0: 0 = `rx_ready` always high in RUN; N≥2 = `rx_ready` low one cycle in every N.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `script_we`  in  1  write strobe for a script word; ignored in RUN.
- `script_addr`  in  $clog2(SCRIPT_DEPTH)  script write address.
- `script_data`  in  DATA_W  script write data.
- `script_len`  in  $clog2(SCRIPT_DEPTH)+1  number of words to send; sampled at `start`.
- `start`  in  1  one-cycle pulse; starts a run from IDLE or DONE, ignored in RUN.
- `tx_valid`  out  1  script word valid toward the SoC.
- `tx_data`  out  DATA_W  script word.
- `tx_ready`  in  1  SoC accepts the word.
- `rx_valid`  in  1  SoC output word valid.
- `rx_data`  in  DATA_W  SoC output word.
- `rx_ready`  out  1  harness accepts a word.
- `cap_addr`  in  $clog2(CAPTURE_DEPTH)  capture read address.
- `cap_data`  out  DATA_W  capture word, one-cycle read latency.
- `done`, `passed`, `timed_out`, `overflow`  out  1 each  status flags.
- `rx_count`  out  16  accepted rx words (saturating).
- `cycle_count`  out  32  cycles spent in the current or last RUN.

## Operation
- FSM IDLE → RUN on `start`. RUN → DONE on END_WORD accept or on timeout. DONE → RUN on `start`. Reset → IDLE.
- On RUN entry: clear `tx_idx`, `rx_count`, `cycle_count` and all flags, and latch `script_len`.
- TX side: `tx_valid`=1 while `tx_idx` < latched length.
  - A word is transferred on `tx_valid & tx_ready`, after which `tx_idx` increments.
  - `tx_data` must stay stable while `tx_valid & !tx_ready`.
  - A zero-length script never asserts `tx_valid`.
- RX side: a word is accepted on `rx_valid & rx_ready`.
  - It is written to `capture[rx_count]` while `rx_count` < CAPTURE_DEPTH; once the buffer is full, `overflow` is set and the word is not stored.
  - `rx_count` counts every accept and saturates at 16'hFFFF.
- Stall: a mod-N counter runs in RUN; `rx_ready` = 0 when the counter is N-1, otherwise 1. `rx_ready` = 0 outside RUN.
- End: accepting END_WORD sets `done`=1 and `passed` = (`tx_idx` == latched length). The END word is captured.
- Timeout: `cycle_count` increments every RUN cycle. When it equals TIMEOUT-1 and no END_WORD is accepted that cycle, the next state is DONE with `timed_out`=1 and `passed`=0.
- Simultaneous END accept and timeout: END wins, so `timed_out`=0.
- DONE holds all flags and counts; `tx_valid`=0 and `rx_ready`=0.

## Timing
- Reset values: `tx_valid`, `tx_data`, `rx_ready`, all flags, `rx_count` and `cycle_count` are 0; the FSM is IDLE. Script and capture memories are not cleared.
- Reset asserted mid-RUN: outputs take their reset values in the cycle after the reset edge, with no further transfers.
- `start` at edge t puts the FSM in RUN at t+1. `tx_valid` (if length > 0) and `rx_ready` first go high in cycle t+1.
- The TX path can sustain 1 word per cycle. `tx_data` is read from script memory combinationally, or by a prefetch such that no bubble exists between back-to-back transfers.
- `done` rises in the cycle after the END accept or the timeout cycle.
- `cycle_count` at DONE equals the number of RUN cycles, which is TIMEOUT on a timeout.

## Structure
- Package `sim_harness_pkg`: enum `state_t` {IDLE, RUN, DONE}, localparam `DEFAULT_END_WORD`, and a `clog2` helper if the toolflow needs one.
- Sub-module `sim_word_ram` (one write port, one read port, parametrised width/depth), instantiated twice: for the script (asynchronous read) and for the capture buffer (registered read).
- Top level: FSM, tx index, rx/cycle/stall counters. Target is about 200 lines.

## Test plan
- Script 68 69 04 (len 3), loopback DUT model echoing each tx word 2 cycles later → `done`=1, `passed`=1, capture[0..2] = 68 69 04, `rx_count`=3.
- TIMEOUT=50 with a silent DUT → `done`=1 and `timed_out`=1 at cycle 50, `passed`=0, `cycle_count`=50.
- `tx_ready` held low 10 cycles mid-script → `tx_valid`=1 and `tx_data` unchanged throughout; no word is skipped or duplicated.
- RX_STALL_PERIOD=4, DUT streaming 12 words, the last being 04 → `rx_ready` low on every 4th RUN cycle, all 12 words captured in order.
- 20 words received with CAPTURE_DEPTH=16, the last being END_WORD → `overflow`=1, `rx_count`=20, capture holds the first 16 words.
- END_WORD accepted on cycle TIMEOUT-1 → `passed`=1, `timed_out`=0. Separately, reset asserted mid-RUN → all outputs are 0 the next cycle, and a following `start` runs cleanly.
